ym_ch_accum_mux: RTL and testbench
==================================

Name: ym_ch_accum_mux

Overview:
- Parametrised channel accumulator and DAC-substitution stage for the FM output path.
- Sums the operator outputs of each channel over one frame of slots, in TDM order, with signed saturation.
- Substitutes the 8-bit DAC sample on one selectable channel.
- Emits one finished sample per channel as a strobed stream to the output mixer.
- Generalises the fixed 6-channel/9-bit accumulator to arbitrary channel count, operator count and accumulator width, and adds per-channel saturation flags and frame-alignment checking.

Parameters:
- CHANNELS, 6, channels per frame (>=2).
- OPS, 4, operator slots per channel per frame (>=1).
- OP_WIDTH, 9, signed operator value width.
- ACC_WIDTH, 9, signed accumulator/output width (>=OP_WIDTH, >=9).
- DAC_CH, 5, channel index replaced by the DAC when enabled (<CHANNELS).

Ports:
- MCLK  in  1  master clock.
- IC  in  1  reset; asynchronous, active-low.
- slot_en  in  1  slot advance strobe; all state changes only on MCLK edges with slot_en=1.
- frame_sync  in  1  marks the current slot as slot 0 (ch 0, op 0).
- op_value  in  OP_WIDTH  signed operator output for the current slot.
- op_out  in  1  current operator contributes to its channel sum.
- dac_en  in  1  DAC mode enable.
- dac  in  8  DAC sample, offset binary.
- dac_lsb  in  1  extra DAC LSB.
- ch_out  out  ACC_WIDTH  finished channel sample, signed.
- ch_idx  out  clog2(CHANNELS)  channel of ch_out.
- ch_valid  out  1  one-MCLK pulse: new ch_out/ch_idx.
- ch_sat  out  1  the channel's sum clipped at least once this frame; valid with ch_valid.
- frame_err  out  1  one-MCLK pulse: frame_sync arrived off-boundary.

Behaviour:
- Slot position: ch_cnt (0..CHANNELS-1) and op_cnt (0..OPS-1).
  - Each slot_en: ch_cnt increments. On wrap, ch_cnt goes to 0 and op_cnt increments. When op_cnt also wraps, op_cnt goes to 0.
  - Slot order is channel-major within op: all channels for op 0, then all channels for op 1, and so on.
- frame_sync with slot_en: the current slot is processed as ch=0, op=0. Counters become ch=1, op=0 (or ch=0, op=1 if CHANNELS=1, which is excluded).
- frame_sync is ignored without slot_en.
- frame_err:
  - Pulses on the next MCLK when frame_sync and slot_en are both high and the counters were not at (0,0).
  - Processing still realigns to slot 0.
  - The interrupted channel's partial sums continue from the realigned position; no clearing beyond the normal op-0 rule.
- Per-slot arithmetic, for ch = current channel:
  - base = 0 if op==0, else acc[ch].
  - addend = op_out ? sign_ext(op_value) : 0.
  - raw = base + addend, computed at ACC_WIDTH+1 bits.
  - sat = clamp raw to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - clip = (raw != sat).
  - satf = (op==0 ? 0 : satf[ch]) | clip.
- If op < OPS-1: acc[ch] <= sat and satf[ch] <= satf. No output.
- If op == OPS-1 (final slot for ch):
  - ch_out <= dsel ? dac_val : sat, where dsel = dac_en & (ch==DAC_CH).
  - dac_val: {~dac[7], dac[6:0], dac_lsb} in the top 9 bits, zeros below, i.e. signed.
  - ch_sat <= dsel ? 0 : satf.
  - ch_idx <= ch; ch_valid pulses for one MCLK.
  - acc[ch] is don't-care (overwritten at the next op 0).
- Output latency: ch_out, ch_idx, ch_valid and ch_sat update one MCLK after the final-slot edge. ch_out, ch_idx and ch_sat hold until the next final slot.
- When dsel=1, operator values are still summed internally (state unchanged by DAC mode); only the output is replaced.
- dac and dac_en are sampled only in the final slot of DAC_CH.
- OPS=1: every slot is both first and final; the output is the clamped sign-extended operator value.
- Reset (IC=0, asynchronous, any time including mid-frame):
  - Counters go to (0,0); acc and satf are all 0.
  - ch_out=0, ch_idx=0, ch_valid=0, ch_sat=0, frame_err=0.
  - The first slot after release is treated as slot 0.

Test Plan:
- Defaults: frame_sync at slot 0, op_out=1, op_value=+10 on every slot. Expect 6 ch_valid pulses per 24-slot frame, ch_idx 0..5 in order, ch_out=+40, ch_sat=0.
- Saturation: ch 2 all ops = +200 (9-bit). Expect ch 2 ch_out=+255, ch_sat=1. Same with -200: expect ch_out=-256, ch_sat=1. Other channels have ch_sat=0.
- Masking and negative: ch 1 values +100,-30,+5,+7 with op_out=1,0,1,1. Expect ch_out=+112.
- DAC: dac_en=1, dac=8'h80, dac_lsb=1. Expect ch 5 ch_out=9'h001, ch_sat=0, other channels unaffected. dac=8'h00, lsb=0: expect ch_out=-256.
- Misalignment: frame_sync at slot 7. Expect frame_err pulse, and the next ch_valid has ch_idx=0 after 18 more slot_en. Assert IC low mid-frame: expect all outputs 0 immediately, with correct sums on the first full frame after release.
- Parameter sweep: CHANNELS=8, OPS=2, ACC_WIDTH=12, DAC_CH=7. Expect saturation at +2047/-2048, dac=8'hFF / dac_lsb=1 gives ch_out=12'h7F8, and 8 outputs per 16 slots.

Source files
------------

// File: rtl/ym_ch_accum_mux.sv
// Per-channel operator accumulator with signed saturation and DAC substitution on one channel.
// Emits one finished sample per channel per frame as a strobed stream.
module ym_ch_accum_mux #(
  parameter int CHANNELS  = 6,
  parameter int OPS       = 4,
  parameter int OP_WIDTH  = 9,
  parameter int ACC_WIDTH = 9,
  parameter int DAC_CH    = 5,
  localparam int CH_W = $clog2(CHANNELS),
  localparam int OP_W = (OPS > 1) ? $clog2(OPS) : 1
) (
  input  logic                 MCLK,
  input  logic                 IC,
  input  logic                 slot_en,
  input  logic                 frame_sync,
  input  logic [OP_WIDTH-1:0]  op_value,
  input  logic                 op_out,
  input  logic                 dac_en,
  input  logic [7:0]           dac,
  input  logic                 dac_lsb,
  output logic [ACC_WIDTH-1:0] ch_out,
  output logic [CH_W-1:0]      ch_idx,
  output logic                 ch_valid,
  output logic                 ch_sat,
  output logic                 frame_err
);

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [CH_W-1:0]      LAST_CH = CH_W'(CHANNELS - 1);
  localparam logic [OP_W-1:0]      LAST_OP = OP_W'(OPS - 1);
  localparam logic [CH_W-1:0]      DAC_IDX = CH_W'(DAC_CH);

  logic [CH_W-1:0]      ch_cnt_q, ch_cnt_d, eff_ch;
  logic [OP_W-1:0]      op_cnt_q, op_cnt_d, eff_op;
  logic                 first_slot, final_slot, dsel;
  logic [ACC_WIDTH-1:0] acc_rd  [CHANNELS];
  logic                 satf_rd [CHANNELS];
  logic [ACC_WIDTH-1:0] acc_cur;
  logic                 satf_cur;
  logic [ACC_WIDTH:0]   base, addend, raw;
  logic [ACC_WIDTH-1:0] sat_val;
  logic                 clip, satf_new;
  logic [8:0]           dac9;
  logic [ACC_WIDTH-1:0] dac_val;

  logic [ACC_WIDTH-1:0] ch_out_q, ch_out_d;
  logic [CH_W-1:0]      ch_idx_q, ch_idx_d;
  logic                 ch_valid_q, ch_valid_d;
  logic                 ch_sat_q, ch_sat_d;
  logic                 frame_err_q, frame_err_d;

  // frame_sync overrides the counters so the current slot is processed as (ch 0, op 0)
  always_comb begin
    eff_ch     = frame_sync ? '0 : ch_cnt_q;
    eff_op     = frame_sync ? '0 : op_cnt_q;
    first_slot = (eff_op == '0);
    final_slot = (eff_op == LAST_OP);
    ch_cnt_d   = ch_cnt_q;
    op_cnt_d   = op_cnt_q;
    if (slot_en) begin
      if (eff_ch == LAST_CH) begin
        ch_cnt_d = '0;
        op_cnt_d = (eff_op == LAST_OP) ? '0 : eff_op + 1'b1;
      end else begin
        ch_cnt_d = eff_ch + 1'b1;
        op_cnt_d = eff_op;
      end
    end
  end

  // One extra bit of headroom: overflow shows up as the top two bits disagreeing
  always_comb begin
    acc_cur  = acc_rd[eff_ch];
    satf_cur = satf_rd[eff_ch];
    base     = first_slot ? '0 : {acc_cur[ACC_WIDTH-1], acc_cur};
    addend   = op_out ? {{(ACC_WIDTH+1-OP_WIDTH){op_value[OP_WIDTH-1]}}, op_value} : '0;
    raw      = base + addend;
    clip     = raw[ACC_WIDTH] ^ raw[ACC_WIDTH-1];
    sat_val  = clip ? (raw[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : raw[ACC_WIDTH-1:0];
    satf_new = (~first_slot & satf_cur) | clip;
    dac9     = {~dac[7], dac[6:0], dac_lsb};
    dac_val  = '0;
    dac_val[ACC_WIDTH-1 -: 9] = dac9;
    dsel     = dac_en & (eff_ch == DAC_IDX);
  end

  always_comb begin
    ch_out_d    = ch_out_q;
    ch_idx_d    = ch_idx_q;
    ch_sat_d    = ch_sat_q;
    ch_valid_d  = slot_en & final_slot;
    frame_err_d = slot_en & frame_sync & ((ch_cnt_q != '0) | (op_cnt_q != '0));
    if (slot_en & final_slot) begin
      ch_out_d = dsel ? dac_val : sat_val;
      ch_sat_d = ~dsel & satf_new;
      ch_idx_d = eff_ch;
    end
  end

  // Per-channel running sum and clip flag; the final-slot write is harmless since op 0 ignores it
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [ACC_WIDTH-1:0] acc_q;
      logic                 satf_q;
      logic                 wr_en;
      assign wr_en = slot_en & (eff_ch == CH_W'(gi));
      always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
          acc_q  <= '0;
          satf_q <= 1'b0;
        end else if (wr_en) begin
          acc_q  <= sat_val;
          satf_q <= satf_new;
        end
      end
      assign acc_rd[gi]  = acc_q;
      assign satf_rd[gi] = satf_q;
    end
  endgenerate

  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      ch_cnt_q    <= '0;
      op_cnt_q    <= '0;
      ch_out_q    <= '0;
      ch_idx_q    <= '0;
      ch_valid_q  <= 1'b0;
      ch_sat_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      ch_cnt_q    <= ch_cnt_d;
      op_cnt_q    <= op_cnt_d;
      ch_out_q    <= ch_out_d;
      ch_idx_q    <= ch_idx_d;
      ch_valid_q  <= ch_valid_d;
      ch_sat_q    <= ch_sat_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign ch_out    = ch_out_q;
  assign ch_idx    = ch_idx_q;
  assign ch_valid  = ch_valid_q;
  assign ch_sat    = ch_sat_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ym_ch_accum_mux.sv
// Directed bench: default 6x4 instance plus an 8x2, 12-bit instance for the parameter sweep.
module tb_ym_ch_accum_mux;

  logic MCLK = 1'b0;
  logic IC   = 1'b0;
  always #5 MCLK = ~MCLK;

  // default instance
  logic       slot_en = 0, frame_sync = 0, op_out = 0, dac_en = 0, dac_lsb = 0;
  logic [8:0] op_value = '0;
  logic [7:0] dac = '0;
  logic [8:0] ch_out;
  logic [2:0] ch_idx;
  logic       ch_valid, ch_sat, frame_err;

  // sweep instance
  logic        s2_slot_en = 0, s2_frame_sync = 0, s2_op_out = 0, s2_dac_en = 0, s2_dac_lsb = 0;
  logic [11:0] s2_op_value = '0;
  logic [7:0]  s2_dac = '0;
  logic [11:0] s2_ch_out;
  logic [2:0]  s2_ch_idx;
  logic        s2_ch_valid, s2_ch_sat, s2_frame_err;

  ym_ch_accum_mux u_dut (
    .MCLK(MCLK), .IC(IC), .slot_en(slot_en), .frame_sync(frame_sync),
    .op_value(op_value), .op_out(op_out), .dac_en(dac_en), .dac(dac), .dac_lsb(dac_lsb),
    .ch_out(ch_out), .ch_idx(ch_idx), .ch_valid(ch_valid), .ch_sat(ch_sat), .frame_err(frame_err)
  );

  ym_ch_accum_mux #(.CHANNELS(8), .OPS(2), .OP_WIDTH(12), .ACC_WIDTH(12), .DAC_CH(7)) u_dut2 (
    .MCLK(MCLK), .IC(IC), .slot_en(s2_slot_en), .frame_sync(s2_frame_sync),
    .op_value(s2_op_value), .op_out(s2_op_out), .dac_en(s2_dac_en), .dac(s2_dac), .dac_lsb(s2_dac_lsb),
    .ch_out(s2_ch_out), .ch_idx(s2_ch_idx), .ch_valid(s2_ch_valid), .ch_sat(s2_ch_sat),
    .frame_err(s2_frame_err)
  );

  int total = 0;
  int bad   = 0;
  int cap_idx[$];
  int cap_out[$];
  int cap_sat[$];
  int fv[6][4];
  bit fm[6][4];
  int exp_out[8];
  int exp_sat[8];

  task automatic clear_caps();
    cap_idx.delete(); cap_out.delete(); cap_sat.delete();
  endtask

  task automatic fill_frame(input int v);
    for (int c = 0; c < 6; c++)
      for (int o = 0; o < 4; o++) begin
        fv[c][o] = v; fm[c][o] = 1'b1;
      end
  endtask

  task automatic slot1(input logic fs, input int v, input logic m);
    slot_en = 1'b1; frame_sync = fs; op_value = 9'(v); op_out = m;
    @(posedge MCLK); #1;
    slot_en = 1'b0; frame_sync = 1'b0;
    if (ch_valid) begin
      cap_idx.push_back(int'(ch_idx));
      cap_out.push_back(int'($signed(ch_out)));
      cap_sat.push_back(int'(ch_sat));
      $display("dut1 sample idx=%0d out=%0d sat=%0d", ch_idx, $signed(ch_out), ch_sat);
    end
  endtask

  task automatic slot2(input logic fs, input int v);
    s2_slot_en = 1'b1; s2_frame_sync = fs; s2_op_value = 12'(v); s2_op_out = 1'b1;
    @(posedge MCLK); #1;
    s2_slot_en = 1'b0; s2_frame_sync = 1'b0;
    if (s2_ch_valid) begin
      cap_idx.push_back(int'(s2_ch_idx));
      cap_out.push_back(int'($signed(s2_ch_out)));
      cap_sat.push_back(int'(s2_ch_sat));
      $display("dut2 sample idx=%0d out=%0d sat=%0d", s2_ch_idx, $signed(s2_ch_out), s2_ch_sat);
    end
  endtask

  task automatic run_frame1(input logic use_fs);
    clear_caps();
    for (int o = 0; o < 4; o++)
      for (int c = 0; c < 6; c++)
        slot1(use_fs && o == 0 && c == 0, fv[c][o], fm[c][o]);
  endtask

  task automatic test_reset();
    IC = 1'b0;
    repeat (3) @(posedge MCLK);
    #1;
    total++; if (ch_out !== 9'd0) begin bad++; $display("FAIL reset_out got=%0h exp=0", ch_out); end
    total++; if (ch_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", ch_idx); end
    total++; if ({ch_valid, ch_sat, frame_err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {ch_valid, ch_sat, frame_err}); end
    total++; if ({s2_ch_out, s2_ch_valid, s2_ch_sat} !== 14'd0) begin bad++; $display("FAIL reset_dut2 got=%0h exp=0", {s2_ch_out, s2_ch_valid, s2_ch_sat}); end
    @(negedge MCLK); IC = 1'b1;
  endtask

  task automatic test_defaults();
    fill_frame(10);
    run_frame1(1'b1);
    total++; if (cap_idx.size() !== 6) begin bad++; $display("FAIL dflt_count got=%0d exp=6", cap_idx.size()); end
    for (int i = 0; i < 6 && i < cap_idx.size(); i++) begin
      total++; if (cap_idx[i] !== i)  begin bad++; $display("FAIL dflt_idx[%0d] got=%0d exp=%0d", i, cap_idx[i], i); end
      total++; if (cap_out[i] !== 40) begin bad++; $display("FAIL dflt_out[%0d] got=%0d exp=40", i, cap_out[i]); end
      total++; if (cap_sat[i] !== 0)  begin bad++; $display("FAIL dflt_sat[%0d] got=%0d exp=0", i, cap_sat[i]); end
    end
    @(posedge MCLK); #1;
    total++; if (ch_valid !== 1'b0) begin bad++; $display("FAIL dflt_pulse got=%b exp=0", ch_valid); end
    total++; if ($signed(ch_out) !== 40 || ch_idx !== 3'd5) begin bad++; $display("FAIL dflt_hold got=%0d/%0d exp=40/5", $signed(ch_out), ch_idx); end
  endtask

  task automatic test_saturation();
    for (int s = 0; s < 2; s++) begin
      fill_frame(10);
      for (int o = 0; o < 4; o++) fv[2][o] = (s == 0) ? 200 : -200;
      for (int c = 0; c < 6; c++) begin exp_out[c] = 40; exp_sat[c] = 0; end
      exp_out[2] = (s == 0) ? 255 : -256;
      exp_sat[2] = 1;
      run_frame1(1'b1);
      total++; if (cap_idx.size() !== 6) begin bad++; $display("FAIL sat%0d_count got=%0d exp=6", s, cap_idx.size()); end
      for (int i = 0; i < 6 && i < cap_idx.size(); i++) begin
        total++; if (cap_out[i] !== exp_out[i]) begin bad++; $display("FAIL sat%0d_out[%0d] got=%0d exp=%0d", s, i, cap_out[i], exp_out[i]); end
        total++; if (cap_sat[i] !== exp_sat[i]) begin bad++; $display("FAIL sat%0d_flag[%0d] got=%0d exp=%0d", s, i, cap_sat[i], exp_sat[i]); end
      end
    end
  endtask

  task automatic test_mask();
    fill_frame(-10);
    fv[1][0] = 100; fv[1][1] = -30; fv[1][2] = 5; fv[1][3] = 7;
    fm[1][1] = 1'b0;
    for (int c = 0; c < 6; c++) exp_out[c] = -40;
    exp_out[1] = 112;
    run_frame1(1'b1);
    total++; if (cap_idx.size() !== 6) begin bad++; $display("FAIL mask_count got=%0d exp=6", cap_idx.size()); end
    for (int i = 0; i < 6 && i < cap_idx.size(); i++) begin
      total++; if (cap_out[i] !== exp_out[i]) begin bad++; $display("FAIL mask_out[%0d] got=%0d exp=%0d", i, cap_out[i], exp_out[i]); end
      total++; if (cap_sat[i] !== 0) begin bad++; $display("FAIL mask_sat[%0d] got=%0d exp=0", i, cap_sat[i]); end
    end
  endtask

  // ch 5 is driven into saturation so the forced-zero ch_sat in DAC mode is visible
  task automatic test_dac();
    for (int s = 0; s < 3; s++) begin
      fill_frame(10);
      for (int o = 0; o < 4; o++) fv[5][o] = 200;
      dac_en  = (s != 2);
      dac     = (s == 0) ? 8'h80 : 8'h00;
      dac_lsb = (s == 0);
      for (int c = 0; c < 6; c++) begin exp_out[c] = 40; exp_sat[c] = 0; end
      exp_out[5] = (s == 0) ? 1 : (s == 1) ? -256 : 255;
      exp_sat[5] = (s == 2) ? 1 : 0;
      run_frame1(1'b1);
      total++; if (cap_idx.size() !== 6) begin bad++; $display("FAIL dac%0d_count got=%0d exp=6", s, cap_idx.size()); end
      for (int i = 0; i < 6 && i < cap_idx.size(); i++) begin
        total++; if (cap_out[i] !== exp_out[i]) begin bad++; $display("FAIL dac%0d_out[%0d] got=%0d exp=%0d", s, i, cap_out[i], exp_out[i]); end
        total++; if (cap_sat[i] !== exp_sat[i]) begin bad++; $display("FAIL dac%0d_sat[%0d] got=%0d exp=%0d", s, i, cap_sat[i], exp_sat[i]); end
      end
    end
    dac_en = 1'b0; dac = 8'h00; dac_lsb = 1'b0;
  endtask

  task automatic test_misalign();
    clear_caps();
    for (int k = 0; k < 7; k++) slot1(k == 0, 10, 1'b1);
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL mis_noerr got=%b exp=0", frame_err); end
    slot1(1'b1, 10, 1'b1);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL mis_err got=%b exp=1", frame_err); end
    slot1(1'b0, 10, 1'b1);
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL mis_errpulse got=%b exp=0", frame_err); end
    for (int k = 1; k < 17; k++) slot1(1'b0, 10, 1'b1);
    total++; if (cap_idx.size() !== 0) begin bad++; $display("FAIL mis_early got=%0d exp=0", cap_idx.size()); end
    slot1(1'b0, 10, 1'b1);
    total++; if (cap_idx.size() !== 1) begin bad++; $display("FAIL mis_count got=%0d exp=1", cap_idx.size()); end
    if (cap_idx.size() > 0) begin
      total++; if (cap_idx[0] !== 0)  begin bad++; $display("FAIL mis_idx got=%0d exp=0", cap_idx[0]); end
      total++; if (cap_out[0] !== 40) begin bad++; $display("FAIL mis_out got=%0d exp=40", cap_out[0]); end
    end
  endtask

  // entered right after a final slot, so ch_valid and ch_out are non-zero when IC drops
  task automatic test_reset_midframe();
    #2 IC = 1'b0;
    #1;
    total++; if (ch_out !== 9'd0 || ch_idx !== 3'd0) begin bad++; $display("FAIL rst_mid_out got=%0h/%0d exp=0/0", ch_out, ch_idx); end
    total++; if ({ch_valid, ch_sat, frame_err} !== 3'b000) begin bad++; $display("FAIL rst_mid_flags got=%b exp=000", {ch_valid, ch_sat, frame_err}); end
    @(negedge MCLK); IC = 1'b1;
    for (int c = 0; c < 6; c++) begin
      for (int o = 0; o < 4; o++) begin fv[c][o] = c * 10 + o; fm[c][o] = 1'b1; end
      exp_out[c] = 40 * c + 6;
    end
    run_frame1(1'b0);
    total++; if (cap_idx.size() !== 6) begin bad++; $display("FAIL rst_frame_count got=%0d exp=6", cap_idx.size()); end
    for (int i = 0; i < 6 && i < cap_idx.size(); i++) begin
      total++; if (cap_idx[i] !== i) begin bad++; $display("FAIL rst_frame_idx[%0d] got=%0d exp=%0d", i, cap_idx[i], i); end
      total++; if (cap_out[i] !== exp_out[i]) begin bad++; $display("FAIL rst_frame_out[%0d] got=%0d exp=%0d", i, cap_out[i], exp_out[i]); end
    end
  endtask

  task automatic test_sweep();
    int v2[8][2];
    v2[0][0] = 1500;  v2[0][1] = 1500;  exp_out[0] = 2047;  exp_sat[0] = 1;
    v2[1][0] = -1500; v2[1][1] = -1500; exp_out[1] = -2048; exp_sat[1] = 1;
    v2[2][0] = 100;   v2[2][1] = -30;   exp_out[2] = 70;    exp_sat[2] = 0;
    for (int c = 3; c < 8; c++) begin
      v2[c][0] = c * 10; v2[c][1] = c * 10; exp_out[c] = c * 20; exp_sat[c] = 0;
    end
    exp_out[7] = 12'h7F8;
    s2_dac_en = 1'b1; s2_dac = 8'hFF; s2_dac_lsb = 1'b1;
    clear_caps();
    for (int o = 0; o < 2; o++)
      for (int c = 0; c < 8; c++)
        slot2(o == 0 && c == 0, v2[c][o]);
    total++; if (cap_idx.size() !== 8) begin bad++; $display("FAIL sweep_count got=%0d exp=8", cap_idx.size()); end
    for (int i = 0; i < 8 && i < cap_idx.size(); i++) begin
      total++; if (cap_idx[i] !== i) begin bad++; $display("FAIL sweep_idx[%0d] got=%0d exp=%0d", i, cap_idx[i], i); end
      total++; if (cap_out[i] !== exp_out[i]) begin bad++; $display("FAIL sweep_out[%0d] got=%0d exp=%0d", i, cap_out[i], exp_out[i]); end
      total++; if (cap_sat[i] !== exp_sat[i]) begin bad++; $display("FAIL sweep_sat[%0d] got=%0d exp=%0d", i, cap_sat[i], exp_sat[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_saturation();
    test_mask();
    test_dac();
    test_misalign();
    test_reset_midframe();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
